// File: rtl/lcd_tile_streamer_if.sv
// Tile streamer bus: frameblock buffer read port plus the LCD 9-bit command/data word stream.
interface lcd_tile_streamer_if #(
  parameter int ID_W      = 7,
  parameter int ADDR_W    = 10,
  parameter int PIX_BYTES = 2
) ();

  logic [ID_W-1:0]        tile_id;
  logic                   tile_ready;
  logic                   tile_next;
  logic [ADDR_W-1:0]      tile_addr;
  logic [8*PIX_BYTES-1:0] tile_data;
  logic                   cmd_pull;
  logic [8:0]             cmd_data;

  // Streamer side: reads the buffer, produces the LCD word stream
  modport master (
    input  tile_id,
    input  tile_ready,
    input  tile_data,
    input  cmd_pull,
    output tile_next,
    output tile_addr,
    output cmd_data
  );

  // Buffer / LCD driver side
  modport slave (
    output tile_id,
    output tile_ready,
    output tile_data,
    output cmd_pull,
    input  tile_next,
    input  tile_addr,
    input  cmd_data
  );

endinterface

// File: rtl/lcd_tile_streamer.sv
// Streams rendered tiles from the frameblock buffer to the LCD as
// CASET/PASET window, RAMWR and MSB-first pixel bytes. Every step is
// paced by cmd_pull from the LCD bus driver; cmd_data is registered.
module lcd_tile_streamer #(
  parameter int TILE_W       = 4,
  parameter int TILE_H       = 240,
  parameter int TILES_X_LOG2 = 7,
  parameter int ID_W         = 7,
  parameter int PIX_BYTES    = 2,
  parameter int ADDR_W       = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                init_done,
  lcd_tile_streamer_if.master bus
);

  localparam int                NPIX      = TILE_W * TILE_H;
  localparam int                PW        = 8 * PIX_BYTES;
  localparam logic [ADDR_W-1:0] LAST_PIX  = ADDR_W'(NPIX - 1);
  localparam logic [2:0]        LAST_BYTE = 3'(PIX_BYTES - 1);
  localparam logic [2:0]        LAST_WIN  = 3'd4;
  localparam logic [8:0]        NOP       = 9'h100;
  localparam logic [8:0]        CASET     = 9'h12A;
  localparam logic [8:0]        PASET     = 9'h12B;
  localparam logic [8:0]        RAMWR     = 9'h12C;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_CAS,
    S_PAS,
    S_RAMW,
    S_PIX
  } state_t;

  state_t state_reg, state_next;

  logic [8:0]        cmd_data_reg,  cmd_data_next;
  logic [ADDR_W-1:0] tile_addr_reg, tile_addr_next;
  logic              tile_next_reg, tile_next_next;
  logic [ID_W-1:0]   id_reg,        id_next;
  logic [PW-1:0]     pix_reg,       pix_next;
  logic [ADDR_W-1:0] pix_cnt_reg,   pix_cnt_next;
  logic [2:0]        byte_cnt_reg,  byte_cnt_next;

  // Window coordinates of the latched tile, 16-bit wraparound arithmetic
  logic [TILES_X_LOG2-1:0] tx;
  logic [15:0]             tx_w, ty_w;
  logic [15:0]             x0, x1, y0, y1;

  assign tx   = id_reg[TILES_X_LOG2-1:0];
  assign tx_w = 16'(tx);
  assign ty_w = 16'(id_reg >> TILES_X_LOG2);
  assign x0   = tx_w * 16'(TILE_W);
  assign x1   = x0 + 16'(TILE_W - 1);
  assign y0   = ty_w * 16'(TILE_H);
  assign y1   = y0 + 16'(TILE_H - 1);

  // CASET and PASET share one 5-word sequencer; only command and values differ
  logic        win_sel_pas;
  logic [8:0]  win_cmd;
  logic [15:0] win_start, win_end;
  logic        win_last;

  assign win_sel_pas = (state_reg == S_PAS);
  assign win_cmd     = win_sel_pas ? PASET : CASET;
  assign win_start   = win_sel_pas ? y0 : x0;
  assign win_end     = win_sel_pas ? y1 : x1;
  assign win_last    = (byte_cnt_reg == LAST_WIN);

  // Byte lanes of the held pixel, lane 0 is the most significant byte
  logic [7:0] pix_lane [PIX_BYTES];
  logic [7:0] pix_byte;
  logic [7:0] head_byte;
  logic       last_pix;
  logic       pix_last_byte;

  genvar gi;
  generate
    for (gi = 0; gi < PIX_BYTES; gi++) begin : g_lane
      assign pix_lane[gi] = pix_reg[8*(PIX_BYTES-1-gi) +: 8];
    end
  endgenerate

  assign head_byte     = bus.tile_data[PW-1 -: 8];
  assign last_pix      = (pix_cnt_reg == LAST_PIX);
  assign pix_last_byte = (byte_cnt_reg == LAST_BYTE);

  // Select the held-pixel lane addressed by the byte counter
  always_comb begin
    pix_byte = pix_lane[0];
    for (int i = 1; i < PIX_BYTES; i++) begin
      if (byte_cnt_reg == 3'(i)) begin
        pix_byte = pix_lane[i];
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: the sequence only advances on a driver pull
  always_comb begin
    state_next = state_reg;
    if (bus.cmd_pull) begin
      case (state_reg)
        S_IDLE:  if (init_done) state_next = S_WAIT;
        S_WAIT:  if (bus.tile_ready) state_next = S_CAS;
        S_CAS:   if (win_last) state_next = S_PAS;
        S_PAS:   if (win_last) state_next = S_RAMW;
        S_RAMW:  state_next = S_PIX;
        S_PIX:   if (pix_last_byte && last_pix) state_next = S_WAIT;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Output logic: next word, buffer address prefetch and counters for each pull
  always_comb begin
    cmd_data_next  = cmd_data_reg;
    tile_addr_next = tile_addr_reg;
    tile_next_next = 1'b0;
    id_next        = id_reg;
    pix_next       = pix_reg;
    pix_cnt_next   = pix_cnt_reg;
    byte_cnt_next  = byte_cnt_reg;
    if (bus.cmd_pull) begin
      case (state_reg)
        S_IDLE: begin
          cmd_data_next = NOP;
          byte_cnt_next = 3'd0;
        end
        S_WAIT: begin
          cmd_data_next = NOP;
          if (bus.tile_ready) begin
            id_next       = bus.tile_id;
            byte_cnt_next = 3'd0;
          end
        end
        S_CAS, S_PAS: begin
          case (byte_cnt_reg)
            3'd0:    cmd_data_next = win_cmd;
            3'd1:    cmd_data_next = {1'b0, win_start[15:8]};
            3'd2:    cmd_data_next = {1'b0, win_start[7:0]};
            3'd3:    cmd_data_next = {1'b0, win_end[15:8]};
            default: cmd_data_next = {1'b0, win_end[7:0]};
          endcase
          byte_cnt_next = win_last ? 3'd0 : byte_cnt_reg + 3'd1;
        end
        S_RAMW: begin
          cmd_data_next = RAMWR;
          byte_cnt_next = 3'd0;
          pix_cnt_next  = '0;
        end
        S_PIX: begin
          if (byte_cnt_reg == 3'd0) begin
            // Capture the prefetched pixel and point the buffer at the next one
            cmd_data_next = {1'b0, head_byte};
            pix_next      = bus.tile_data;
            if (!last_pix) begin
              tile_addr_next = tile_addr_reg + ADDR_W'(1);
            end
          end else begin
            cmd_data_next = {1'b0, pix_byte};
          end
          if (pix_last_byte) begin
            byte_cnt_next = 3'd0;
            if (last_pix) begin
              tile_next_next = 1'b1;
              tile_addr_next = '0;
              pix_cnt_next   = '0;
            end else begin
              pix_cnt_next = pix_cnt_reg + ADDR_W'(1);
            end
          end else begin
            byte_cnt_next = byte_cnt_reg + 3'd1;
          end
        end
        default: cmd_data_next = NOP;
      endcase
    end
  end

  // Datapath registers: output word, address, tile_next pulse, latched id and pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_data_reg  <= NOP;
      tile_addr_reg <= '0;
      tile_next_reg <= 1'b0;
      id_reg        <= '0;
      pix_reg       <= '0;
      pix_cnt_reg   <= '0;
      byte_cnt_reg  <= 3'd0;
    end else begin
      cmd_data_reg  <= cmd_data_next;
      tile_addr_reg <= tile_addr_next;
      tile_next_reg <= tile_next_next;
      id_reg        <= id_next;
      pix_reg       <= pix_next;
      pix_cnt_reg   <= pix_cnt_next;
      byte_cnt_reg  <= byte_cnt_next;
    end
  end

  assign bus.cmd_data  = cmd_data_reg;
  assign bus.tile_addr = tile_addr_reg;
  assign bus.tile_next = tile_next_reg;

endmodule

// File: tb/tb_lcd_tile_streamer.sv
// Bench for lcd_tile_streamer: a default instance (4x240, RGB565) and a
// small instance (4x60, 4 tiles per row, 3 bytes per pixel), each with
// its own 1-cycle-latency buffer model and a word-stream reference model.
module tb_lcd_tile_streamer;

  localparam int A_NPIX = 960;
  localparam int B_NPIX = 240;
  localparam int HDR    = 11;

  logic clk = 1'b0;
  logic rst_n;
  logic init_done;

  always #5 clk = ~clk;

  lcd_tile_streamer_if #(.ID_W(7), .ADDR_W(10), .PIX_BYTES(2)) ia ();
  lcd_tile_streamer_if #(.ID_W(7), .ADDR_W(8),  .PIX_BYTES(3)) ib ();

  lcd_tile_streamer #(
    .TILE_W(4), .TILE_H(240), .TILES_X_LOG2(7), .ID_W(7), .PIX_BYTES(2), .ADDR_W(10)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .init_done(init_done), .bus(ia)
  );

  lcd_tile_streamer #(
    .TILE_W(4), .TILE_H(60), .TILES_X_LOG2(2), .ID_W(7), .PIX_BYTES(3), .ADDR_W(8)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .init_done(init_done), .bus(ib)
  );

  // Frameblock buffers with registered read
  logic [15:0] mem_a [1024];
  logic [23:0] mem_b [256];

  always @(posedge clk) begin
    ia.tile_data <= mem_a[ia.tile_addr];
    ib.tile_data <= mem_b[ib.tile_addr];
  end

  // Monitors: tile_next high cycles, out-of-range reads, pull spacing
  int tn_cnt_a, tn_cnt_b, oob_a, oob_b, spc_cnt;
  bit prev_a, prev_b;

  always @(negedge clk) begin
    if (ia.tile_next === 1'b1) tn_cnt_a <= tn_cnt_a + 1;
    if (ib.tile_next === 1'b1) tn_cnt_b <= tn_cnt_b + 1;
    if (int'(ia.tile_addr) >= A_NPIX) oob_a <= oob_a + 1;
    if (int'(ib.tile_addr) >= B_NPIX) oob_b <= oob_b + 1;
  end

  always @(posedge clk) begin
    prev_a <= ia.cmd_pull;
    prev_b <= ib.cmd_pull;
    if ((prev_a && ia.cmd_pull) || (prev_b && ib.cmd_pull)) spc_cnt <= spc_cnt + 1;
  end

  int tests  = 0;
  int failed = 0;
  logic [8:0] exp_q [$];

  // ---------------- reference model ----------------
  function automatic void push_window(input bit sel_b, input int id);
    int txl, h, tx, ty, x0, x1, y0, y1;
    txl = sel_b ? 2 : 7;
    h   = sel_b ? 60 : 240;
    tx  = id % (1 << txl);
    ty  = id / (1 << txl);
    x0  = (tx * 4) % 65536;
    x1  = (tx * 4 + 3) % 65536;
    y0  = (ty * h) % 65536;
    y1  = (ty * h + h - 1) % 65536;
    exp_q.push_back(9'h12A);
    exp_q.push_back(9'(x0 / 256)); exp_q.push_back(9'(x0 % 256));
    exp_q.push_back(9'(x1 / 256)); exp_q.push_back(9'(x1 % 256));
    exp_q.push_back(9'h12B);
    exp_q.push_back(9'(y0 / 256)); exp_q.push_back(9'(y0 % 256));
    exp_q.push_back(9'(y1 / 256)); exp_q.push_back(9'(y1 % 256));
    exp_q.push_back(9'h12C);
  endfunction

  function automatic void push_pixels(input bit sel_b);
    int npix, pb, v;
    npix = sel_b ? B_NPIX : A_NPIX;
    pb   = sel_b ? 3 : 2;
    for (int n = 0; n < npix; n++) begin
      v = sel_b ? int'(mem_b[n]) : int'(mem_a[n]);
      for (int b = 0; b < pb; b++) exp_q.push_back(9'((v >> (8 * (pb - 1 - b))) % 256));
    end
  endfunction

  function automatic void fill_mem(input bit sel_b, input bit rnd);
    for (int n = 0; n < 1024; n++) mem_a_wr(sel_b, n, rnd);
  endfunction

  function automatic void mem_a_wr(input bit sel_b, input int n, input bit rnd);
    if (sel_b) begin
      if (n < 256) mem_b[n] = rnd ? 24'($urandom) : 24'(n);
    end else begin
      mem_a[n] = rnd ? 16'($urandom) : 16'(n);
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic set_tile(input bit sel_b, input logic ready, input int id);
    if (sel_b) begin ib.tile_ready = ready; ib.tile_id = 7'(id); end
    else       begin ia.tile_ready = ready; ia.tile_id = 7'(id); end
  endtask

  // One pull: held across exactly one edge, result sampled 1 time unit later
  task automatic do_pull(input bit sel_b, output logic [8:0] w, output int a,
                         output logic tn1, output logic tn2);
    if (sel_b) ib.cmd_pull = 1'b1; else ia.cmd_pull = 1'b1;
    @(posedge clk); #1;
    ia.cmd_pull = 1'b0;
    ib.cmd_pull = 1'b0;
    w   = sel_b ? ib.cmd_data : ia.cmd_data;
    a   = sel_b ? int'(ib.tile_addr) : int'(ia.tile_addr);
    tn1 = sel_b ? ib.tile_next : ia.tile_next;
    @(posedge clk); #1;
    tn2 = sel_b ? ib.tile_next : ia.tile_next;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    init_done = 1'b0;
    ia.cmd_pull = 1'b0; ib.cmd_pull = 1'b0;
    set_tile(1'b0, 1'b0, 0);
    set_tile(1'b1, 1'b0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic to_wait(input bit sel_b);
    logic [8:0] w; int a; logic t1, t2;
    init_done = 1'b1;
    do_pull(sel_b, w, a, t1, t2);
    tests++;
    if (w !== 9'h100) begin
      $display("FAIL to_wait_nop: got %h want 100", w); failed++;
    end
  endtask

  // Runs one tile from WAIT against exp_q; stop_after<0 means run it to the end
  task automatic run_tile(input bit sel_b, input int id, input int stop_after,
                          input int next_id, input string name);
    int npix, pb, n_words, last_k, exp_addr, a, j, tn0, oob0;
    logic [8:0] w; logic tn1, tn2, exp_tn; bit bad;
    npix    = sel_b ? B_NPIX : A_NPIX;
    pb      = sel_b ? 3 : 2;
    last_k  = exp_q.size() - 1;
    n_words = (stop_after < 0) ? exp_q.size() : stop_after;
    tn0     = sel_b ? tn_cnt_b : tn_cnt_a;
    oob0    = sel_b ? oob_b : oob_a;
    set_tile(sel_b, 1'b1, id);
    do_pull(sel_b, w, a, tn1, tn2);
    tests++;
    if (w !== 9'h100) begin
      $display("FAIL %s accept_nop: got %h want 100", name, w); failed++;
    end
    // The buffer may drop ready and show garbage; the latched id must be used
    set_tile(sel_b, 1'b0, int'($urandom_range(0, 127)));
    exp_addr = 0;
    bad = 1'b0;
    for (int k = 0; k < n_words && !bad; k++) begin
      if (k == last_k && next_id >= 0) set_tile(sel_b, 1'b1, next_id);
      do_pull(sel_b, w, a, tn1, tn2);
      if (k >= HDR) begin
        j = k - HDR;
        if ((j % pb) == 0 && (j / pb) < npix - 1) exp_addr = j / pb + 1;
        if (k == last_k) exp_addr = 0;
      end
      exp_tn = (k == last_k);
      tests++;
      if (w !== exp_q[k]) begin
        $display("FAIL %s word[%0d]: got %h want %h", name, k, w, exp_q[k]); failed++; bad = 1'b1;
      end
      tests++;
      if (a !== exp_addr) begin
        $display("FAIL %s addr[%0d]: got %0d want %0d", name, k, a, exp_addr); failed++; bad = 1'b1;
      end
      tests++;
      if (tn1 !== exp_tn) begin
        $display("FAIL %s tile_next[%0d]: got %b want %b", name, k, tn1, exp_tn); failed++; bad = 1'b1;
      end
    end
    if (stop_after < 0 && !bad) begin
      tests++;
      if (tn2 !== 1'b0) begin
        $display("FAIL %s tile_next_width: got %b want 0", name, tn2); failed++;
      end
      tests++;
      if ((sel_b ? tn_cnt_b : tn_cnt_a) - tn0 != 1) begin
        $display("FAIL %s tile_next_count: got %0d want 1", name, (sel_b ? tn_cnt_b : tn_cnt_a) - tn0);
        failed++;
      end
      tests++;
      if ((sel_b ? oob_b : oob_a) - oob0 != 0) begin
        $display("FAIL %s addr_range: got %0d out-of-range cycles want 0", name,
                 (sel_b ? oob_b : oob_a) - oob0);
        failed++;
      end
    end
    $display("[TB] tile %s dut=%s id=%0d words=%0d", name, sel_b ? "b" : "a", id, n_words);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    tests++; if (ia.cmd_data !== 9'h100) begin $display("FAIL reset_cmd_a: got %h want 100", ia.cmd_data); failed++; end
    tests++; if (ia.tile_next !== 1'b0) begin $display("FAIL reset_next_a: got %b want 0", ia.tile_next); failed++; end
    tests++; if (ia.tile_addr !== 10'd0) begin $display("FAIL reset_addr_a: got %0d want 0", ia.tile_addr); failed++; end
    tests++; if (ib.cmd_data !== 9'h100) begin $display("FAIL reset_cmd_b: got %h want 100", ib.cmd_data); failed++; end
    tests++; if (ib.tile_next !== 1'b0) begin $display("FAIL reset_next_b: got %b want 0", ib.tile_next); failed++; end
    tests++; if (ib.tile_addr !== 8'd0) begin $display("FAIL reset_addr_b: got %0d want 0", ib.tile_addr); failed++; end
    apply_reset();
  endtask

  task automatic test_default_tile();
    logic [8:0] hdr [HDR];
    apply_reset();
    fill_mem(1'b0, 1'b0);
    hdr = '{9'h12A, 9'h000, 9'h014, 9'h000, 9'h017, 9'h12B, 9'h000, 9'h000, 9'h000, 9'h0EF, 9'h12C};
    exp_q.delete();
    foreach (hdr[i]) exp_q.push_back(hdr[i]);
    push_pixels(1'b0);
    to_wait(1'b0);
    run_tile(1'b0, 5, -1, -1, "default");
  endtask

  task automatic test_geometry();
    logic [8:0] hdr [HDR];
    apply_reset();
    fill_mem(1'b1, 1'b1);
    mem_b[0] = 24'h123456;
    hdr = '{9'h12A, 9'h000, 9'h008, 9'h000, 9'h00B, 9'h12B, 9'h000, 9'h03C, 9'h000, 9'h077, 9'h12C};
    exp_q.delete();
    foreach (hdr[i]) exp_q.push_back(hdr[i]);
    push_pixels(1'b1);
    to_wait(1'b1);
    run_tile(1'b1, 6, -1, -1, "geometry");
  endtask

  task automatic test_random_tiles();
    int id;
    bit sel;
    apply_reset();
    to_wait(1'b0);
    to_wait(1'b1);
    for (int i = 0; i < 5; i++) begin
      sel = (i >= 2);
      id  = int'($urandom_range(0, 127));
      fill_mem(sel, 1'b1);
      exp_q.delete();
      push_window(sel, id);
      push_pixels(sel);
      run_tile(sel, id, -1, -1, "random");
    end
  endtask

  task automatic test_idle_wait();
    logic [8:0] w; int a; logic t1, t2; int id;
    apply_reset();
    for (int i = 0; i < 50; i++) begin
      set_tile(1'b1, 1'b1, i);
      do_pull(1'b1, w, a, t1, t2);
      tests++;
      if (w !== 9'h100 || a != 0 || t1 !== 1'b0) begin
        $display("FAIL idle_nop[%0d]: got cmd=%h addr=%0d next=%b want 100/0/0", i, w, a, t1); failed++;
      end
    end
    init_done = 1'b1;
    set_tile(1'b1, 1'b0, 3);
    for (int i = 0; i < 20; i++) begin
      do_pull(1'b1, w, a, t1, t2);
      tests++;
      if (w !== 9'h100 || a != 0 || t1 !== 1'b0) begin
        $display("FAIL wait_nop[%0d]: got cmd=%h addr=%0d next=%b want 100/0/0", i, w, a, t1); failed++;
      end
    end
    id = int'($urandom_range(0, 127));
    fill_mem(1'b1, 1'b1);
    exp_q.delete();
    push_window(1'b1, id);
    push_pixels(1'b1);
    run_tile(1'b1, id, -1, -1, "after_wait");
  endtask

  task automatic test_reset_mid_tile();
    int id, tn0;
    apply_reset();
    to_wait(1'b1);
    id = int'($urandom_range(0, 127));
    fill_mem(1'b1, 1'b1);
    exp_q.delete();
    push_window(1'b1, id);
    push_pixels(1'b1);
    run_tile(1'b1, id, HDR + 100 * 3, -1, "pre_reset");
    tn0 = tn_cnt_b;
    #3 rst_n = 1'b0;
    #1;
    tests++; if (ib.cmd_data !== 9'h100) begin $display("FAIL midreset_cmd: got %h want 100", ib.cmd_data); failed++; end
    tests++; if (ib.tile_addr !== 8'd0) begin $display("FAIL midreset_addr: got %0d want 0", ib.tile_addr); failed++; end
    tests++; if (ib.tile_next !== 1'b0) begin $display("FAIL midreset_next: got %b want 0", ib.tile_next); failed++; end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (tn_cnt_b != tn0) begin $display("FAIL midreset_no_next: got %0d pulses want 0", tn_cnt_b - tn0); failed++; end
    to_wait(1'b1);
    id = int'($urandom_range(0, 127));
    fill_mem(1'b1, 1'b1);
    exp_q.delete();
    push_window(1'b1, id);
    push_pixels(1'b1);
    run_tile(1'b1, id, -1, -1, "post_reset");
  endtask

  task automatic test_back_to_back();
    int id1, id2;
    apply_reset();
    to_wait(1'b1);
    id1 = int'($urandom_range(0, 127));
    id2 = int'($urandom_range(0, 127));
    fill_mem(1'b1, 1'b1);
    exp_q.delete();
    push_window(1'b1, id1);
    push_pixels(1'b1);
    run_tile(1'b1, id1, -1, id2, "b2b_first");
    fill_mem(1'b1, 1'b1);
    exp_q.delete();
    push_window(1'b1, id2);
    push_pixels(1'b1);
    run_tile(1'b1, id2, -1, -1, "b2b_second");
  endtask

  task automatic test_pull_spacing();
    tests++;
    if (spc_cnt != 0) begin $display("FAIL pull_spacing: got %0d violations want 0", spc_cnt); failed++; end
  endtask

  initial begin
    ia.cmd_pull = 1'b0; ib.cmd_pull = 1'b0;
    ia.tile_ready = 1'b0; ib.tile_ready = 1'b0;
    ia.tile_id = '0; ib.tile_id = '0;
    init_done = 1'b0;
    test_reset();
    test_default_tile();
    test_geometry();
    test_random_tiles();
    test_idle_wait();
    test_reset_mid_tile();
    test_back_to_back();
    test_pull_spacing();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
